down_counter_timer: RTL
=======================

Name: down_counter_timer

Overview:
- Loadable down-counter/timer; the decrementing counterpart of the free-running up counter in Basecell.
- Counts a programmed value down to zero under an enable.
- Flags expiry with a one-cycle pulse and optionally auto-reloads for periodic operation.
- Provides a Start/Ack handshake so pipeline stall timers, refresh timers and timeout watchdogs can arm it, wait for expiry and acknowledge.

Parameters:
- WIDTH, 32, bit width of Count, Load_Value and the internal reload register.

Ports:
- System.Clk  input  1  clock, rising edge; carried in the Global System struct.
- System.Rst  input  1  reset, carried in the Global System struct; asynchronous, active-low (asserted when 0).
- Clr  input  1  synchronous clear of count and state.
- Load  input  1  synchronous load of Load_Value into Count and the reload register.
- Load_Value  input  WIDTH  value to load.
- Start  input  1  arm the timer (honoured in IDLE only).
- Stop  input  1  abort a running count (RUN to IDLE, Count held).
- Reload_En  input  1  when 1, auto-reload on expiry and keep running.
- En  input  1  decrement enable (count qualifier).
- Ack  input  1  acknowledge expiry (DONE to IDLE).
- Count  output  WIDTH  current count, registered.
- Busy  output  1  state==RUN.
- Done  output  1  state==DONE.
- Zero  output  1  Count==0, combinational from the register.
- Expire  output  1  registered one-cycle expiry pulse.

Behaviour:
- Reset, asynchronous (System.Rst=0): Count=0, reload register=0, state=IDLE, Busy=0, Done=0, Expire=0, Zero=1. Effect is immediate and independent of the clock. Release is sampled on the next rising edge.
- States: IDLE, RUN, DONE. All updates occur on the rising edge. Per-cycle priority is Clr > Load > Stop/Ack > Start > decrement.
- Clr (any state): Count<=0, state<=IDLE, Expire<=0. Reload register unchanged.
- Load (any state, Clr=0): Count<=Load_Value, reload<=Load_Value, state<=IDLE, Expire<=0. A Start in the same cycle is ignored.
- IDLE:
  - Start with Count!=0: go to RUN. The first decrement is possible in the following cycle.
  - Start with Count==0: go directly to DONE with Expire=1 for one cycle (zero-length timeout).
  - En has no effect.
- RUN, En=1:
  - Count>1: Count<=Count-1.
  - Count==1 (terminal cycle): Expire<=1 for exactly the next cycle.
    - Reload_En=1 and reload!=0: Count<=reload, stay in RUN. Period is exactly reload En-cycles.
    - Otherwise: Count<=0, go to DONE.
- RUN, En=0: Count holds. Stop: go to IDLE, Count holds its current value; no Expire.
- DONE: Count holds at 0. Ack or Stop: go to IDLE. Start is ignored. Done stays 1 until Ack, Stop, Clr or Load.
- No wrap-around: Count never decrements from 0. A value of 0 in RUN cannot occur except via reload=0, which is treated as non-reload.
- Expire is never asserted in two consecutive cycles unless reload==1 with En held high, which gives a continuous pulse train.
- Width rules: Load_Value is taken at full WIDTH. Decrement is modulo 2^WIDTH but is guarded by the rules above.
- Reset asserted mid-RUN or mid-DONE: outputs return to reset values immediately. No Expire is generated.

Test Plan:
- Reset, then Load_Value=5, Load; Start; En=1 continuously -> Busy=1, Count reads 5,4,3,2,1,0. Expire=1 only in the cycle Count first shows 0. Done=1 and held; Ack -> IDLE, Done=0.
- Load 3, Reload_En=1, Start, En=1 for 10 cycles -> Count 3,2,1,3,2,1,3,... Expire pulses every 3 cycles. Done never set.
- Load 4, Start, En toggled 1,0,1,0 -> Count decrements only in En=1 cycles (4,3,3,2,2). Stop -> IDLE with Count=2; a later Start resumes from 2.
- Load 0, Start -> next cycle Done=1 and Expire=1 for one cycle. Zero=1 throughout; Count stays 0.
- Count=7 in RUN; Clr and Load(9) asserted together -> Count=0, IDLE (Clr wins). Then Load(9) with Start in the same cycle -> Count=9, IDLE, Busy=0.
- Count=6 in RUN; drive System.Rst=0 between clock edges -> Count=0, Busy=0, Done=0, Expire=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//   Loadable down-counter / timer. A programmed value counts down to zero under
//   an enable. Expiry is flagged with a registered one-cycle pulse, and the
//   timer can optionally auto-reload for periodic operation. A Start/Ack
//   handshake lets a client arm the timer, wait for expiry and acknowledge it.
//
// Ports
//   System      : clock (System.Clk, rising edge) and asynchronous
//                 active-low reset (System.Rst)
//   Clr         : synchronous clear of count and state (reload kept)
//   Load        : synchronous load of Load_Value into count and reload
//   Load_Value  : value to load, full WIDTH
//   Start       : arm the timer, honoured in IDLE only
//   Stop        : abort a running count (RUN -> IDLE) or leave DONE
//   Reload_En   : auto-reload on expiry and keep running
//   En          : decrement enable
//   Ack         : acknowledge expiry (DONE -> IDLE)
//   Count       : current count, registered
//   Busy        : timer is running
//   Done        : timer has expired and awaits Ack/Stop
//   Zero        : Count == 0
//   Expire      : registered one-cycle expiry pulse
// -----------------------------------------------------------------------------
package down_counter_timer_pkg;
  typedef struct packed {
    logic Clk;
    logic Rst;
  } system_t;
endpackage

module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  system_t          System,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_Value,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Reload_En,
  input  logic             En,
  input  logic             Ack,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done,
  output logic             Zero,
  output logic             Expire
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             clk;
  logic             rst_n;
  state_t           state;
  logic [WIDTH-1:0] reload;

  assign clk   = System.Clk;
  assign rst_n = System.Rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Count  <= '0;
      reload <= '0;
      state  <= IDLE;
      Expire <= 1'b0;
    end else begin
      // Expire is a single-cycle pulse unless re-armed below.
      Expire <= 1'b0;
      if (Clr) begin
        Count <= '0;
        state <= IDLE;
      end else if (Load) begin
        Count  <= Load_Value;
        reload <= Load_Value;
        state  <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (Start) begin
              if (Count == '0) begin
                // Zero-length timeout: expire straight away.
                state  <= DONE;
                Expire <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (Stop) begin
              state <= IDLE;
            end else if (En) begin
              if (Count > ONE) begin
                Count <= Count - ONE;
              end else begin
                // Terminal cycle. A zero reload value is treated as one-shot,
                // and Count==0 here is folded into the same path so the
                // counter can never wrap.
                Expire <= 1'b1;
                if (Reload_En && (reload != '0)) begin
                  Count <= reload;
                end else begin
                  Count <= '0;
                  state <= DONE;
                end
              end
            end
          end
          DONE: begin
            if (Ack || Stop) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign Busy = (state == RUN);
  assign Done = (state == DONE);
  assign Zero = (Count == '0);

endmodule
